// File: rtl/fakeram130_1rw_ctrl.sv
// Valid/ready front end for a 1RW fakeram130 macro with a credit-protected read-response FIFO.
// Define FAKERAM_CTRL_INIT_EN to zero-fill the whole macro after every reset before accepting requests.
module fakeram130_1rw_ctrl #(
    parameter int unsigned BITS       = 46,
    parameter int unsigned WORD_DEPTH = 1024,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned RESP_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n_in,
    input  logic                  v_in,
    input  logic                  w_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [BITS-1:0]       data_in,
    input  logic [BITS-1:0]       mask_in,
    output logic                  ready_out,
    output logic                  v_out,
    output logic [BITS-1:0]       data_out,
    input  logic                  yumi_in,
    output logic                  ram_ce_out,
    output logic                  ram_we_out,
    output logic [ADDR_WIDTH-1:0] ram_addr_out,
    output logic [BITS-1:0]       ram_wd_out,
    output logic [BITS-1:0]       ram_w_mask_out,
    input  logic [BITS-1:0]       ram_rd_in
);
    localparam int unsigned PtrW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(RESP_DEPTH + 1);

    if (ADDR_WIDTH < $clog2(WORD_DEPTH) || RESP_DEPTH < 1) begin : g_param_check
        $error("fakeram130_1rw_ctrl: inconsistent parameters");
    end

    logic                  run;
    logic [ADDR_WIDTH-1:0] init_addr;
    logic                  acc;
    logic                  enq;
    logic                  deq;
    logic                  inflight_q, inflight_d;
    logic [CntW-1:0]       count_q, count_d;
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [BITS-1:0]       fifo_mem [RESP_DEPTH];

`ifdef FAKERAM_CTRL_INIT_EN
    typedef enum logic [0:0] {StInit, StRun} state_e;
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        if (state_q == StInit) begin
            init_cnt_d = init_cnt_q + 1'b1;
            if (32'(init_cnt_q) == WORD_DEPTH - 1) begin
                state_d    = StRun;
                init_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= StInit;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    assign run       = (state_q == StRun);
    assign init_addr = init_cnt_q;
`else
    assign run       = 1'b1;
    assign init_addr = '0;
`endif

    // Credits: buffered responses plus the read still inside the macro must fit the FIFO.
    assign v_out     = (count_q != '0);
    assign deq       = yumi_in & v_out;
    assign ready_out = run && ((32'(count_q) + 32'(inflight_q)) < (RESP_DEPTH + 32'(deq)));
    assign acc       = v_in & ready_out;
    assign enq       = inflight_q;
    assign data_out  = v_out ? fifo_mem[rd_ptr_q] : '0;

    always_comb begin
        ram_ce_out     = 1'b0;
        ram_we_out     = 1'b0;
        ram_addr_out   = '0;
        ram_wd_out     = '0;
        ram_w_mask_out = '0;
        if (!run) begin
            ram_ce_out     = 1'b1;
            ram_we_out     = 1'b1;
            ram_addr_out   = init_addr;
            ram_w_mask_out = '1;
        end else if (acc) begin
            ram_ce_out     = 1'b1;
            ram_we_out     = w_in;
            ram_addr_out   = addr_in;
            ram_wd_out     = data_in;
            ram_w_mask_out = mask_in;
        end
    end

    always_comb begin
        inflight_d = acc & ~w_in;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (enq) begin
            wr_ptr_d = (32'(wr_ptr_q) == RESP_DEPTH - 1) ? '0 : wr_ptr_q + 1'b1;
        end
        if (deq) begin
            rd_ptr_d = (32'(rd_ptr_q) == RESP_DEPTH - 1) ? '0 : rd_ptr_q + 1'b1;
        end
        if (enq && !deq) begin
            count_d = count_q + 1'b1;
        end else if (!enq && deq) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            inflight_q <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Storage only; validity is tracked by count_q, so no reset is needed.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_mem[wr_ptr_q] <= ram_rd_in;
        end
    end

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n_in)
        !(enq && !deq && 32'(count_q) == RESP_DEPTH))
        else $error("response FIFO enqueue while full");
    a_yumi_legal: assert property (@(posedge clk) disable iff (!rst_n_in)
        !(yumi_in && !v_out))
        else $error("yumi_in asserted without v_out");
`endif

endmodule

// File: tb/tb_fakeram130_1rw_ctrl.sv
// Randomized bench for fakeram130_1rw_ctrl with a behavioural macro and a queue-based reference.
// Define FAKERAM_CTRL_INIT_EN to check the post-reset zero-fill sweep as well.
module tb_fakeram130_1rw_ctrl;
    localparam int BITS = 46;
    localparam int DEPTH = 1024;
    localparam int RESP_DEPTH = 2;
`ifdef FAKERAM_CTRL_INIT_EN
    localparam int INIT_CYC = 1024;
`else
    localparam int INIT_CYC = 0;
`endif
    localparam logic [BITS-1:0] ONES = '1;

    logic            clk = 1'b0;
    logic            rst_n_in = 1'b0;
    logic            v_in = 1'b0, w_in = 1'b0, yumi_in = 1'b0;
    logic [9:0]      addr_in = '0;
    logic [BITS-1:0] data_in = '0, mask_in = '0;
    logic            ready_out, v_out;
    logic [BITS-1:0] data_out;
    logic            ram_ce_out, ram_we_out;
    logic [9:0]      ram_addr_out;
    logic [BITS-1:0] ram_wd_out, ram_w_mask_out;
    logic [BITS-1:0] ram_rd_in = '0;

    fakeram130_1rw_ctrl dut (
        .clk            (clk),
        .rst_n_in       (rst_n_in),
        .v_in           (v_in),
        .w_in           (w_in),
        .addr_in        (addr_in),
        .data_in        (data_in),
        .mask_in        (mask_in),
        .ready_out      (ready_out),
        .v_out          (v_out),
        .data_out       (data_out),
        .yumi_in        (yumi_in),
        .ram_ce_out     (ram_ce_out),
        .ram_we_out     (ram_we_out),
        .ram_addr_out   (ram_addr_out),
        .ram_wd_out     (ram_wd_out),
        .ram_w_mask_out (ram_w_mask_out),
        .ram_rd_in      (ram_rd_in)
    );

    always #5 clk = ~clk;

    // Behavioural macro: masked write, registered read data.
    logic [BITS-1:0] macro_mem [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) macro_mem[i] = {$urandom(), $urandom()};
    always @(posedge clk) begin
        if (ram_ce_out) begin
            if (ram_we_out)
                macro_mem[ram_addr_out] <= (macro_mem[ram_addr_out] & ~ram_w_mask_out)
                                           | (ram_wd_out & ram_w_mask_out);
            else
                ram_rd_in <= macro_mem[ram_addr_out];
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: shadow memory with per-bit knowledge and a queue of accepted reads.
    typedef struct {
        logic [BITS-1:0] data;
        logic [BITS-1:0] kmask;
        int unsigned     vis;
    } resp_t;
    resp_t           pend[$];
    logic [BITS-1:0] shadow [DEPTH];
    logic [BITS-1:0] kmask  [DEPTH];
    int unsigned     cyc = 0;
    int              init_left = INIT_CYC;

    initial for (int i = 0; i < DEPTH; i++) begin
        shadow[i] = '0;
        kmask[i]  = '0;
    end

    initial begin
        bit prev = 0;
        bit l_acc = 0, l_deq = 0, l_w = 0;
        logic [9:0] l_a = '0;
        logic [BITS-1:0] l_d = '0, l_m = '0;
        bit v_e, deq_e, rdy_e, acc_e;
        resp_t r;
        forever begin
            @(negedge clk);
            if (!rst_n_in) begin
                pend.delete();
                init_left = INIT_CYC;
                cyc = 0;
                prev = 0;
                chk("reset_v_out", v_out, 0);
                chk("reset_data_out", data_out, 0);
                chk("reset_ce", ram_ce_out, 0);
            end else begin
                if (prev) begin
                    if (init_left > 0) begin
                        shadow[INIT_CYC-init_left] = '0;
                        kmask[INIT_CYC-init_left] = ONES;
                        init_left--;
                    end
                    if (l_deq) void'(pend.pop_front());
                    if (l_acc) begin
                        if (l_w) begin
                            shadow[l_a] = (shadow[l_a] & ~l_m) | (l_d & l_m);
                            kmask[l_a] = kmask[l_a] | l_m;
                        end else begin
                            r.data = shadow[l_a];
                            r.kmask = kmask[l_a];
                            r.vis = cyc + 2;
                            pend.push_back(r);
                        end
                    end
                    cyc++;
                end
                prev = 1;
                v_e = (pend.size() > 0) && (pend[0].vis <= cyc);
                deq_e = yumi_in && v_e;
                rdy_e = (init_left == 0) && (pend.size() - int'(deq_e) < RESP_DEPTH);
                acc_e = v_in && rdy_e;
                chk("ready_out", ready_out, rdy_e);
                chk("v_out", v_out, v_e);
                if (v_e) chk("data_out", data_out & pend[0].kmask, pend[0].data & pend[0].kmask);
                if (init_left > 0) begin
                    chk("init_ce", ram_ce_out, 1);
                    chk("init_we", ram_we_out, 1);
                    chk("init_addr", ram_addr_out, 64'(INIT_CYC - init_left));
                    chk("init_wd", ram_wd_out, 0);
                    chk("init_mask", ram_w_mask_out, ONES);
                end else begin
                    chk("pin_ce", ram_ce_out, acc_e);
                    chk("pin_we", ram_we_out, acc_e && w_in);
                    chk("pin_addr", ram_addr_out, acc_e ? addr_in : 10'd0);
                    chk("pin_wd", ram_wd_out, acc_e ? data_in : '0);
                    chk("pin_mask", ram_w_mask_out, acc_e ? mask_in : '0);
                end
                l_acc = acc_e;
                l_deq = deq_e;
                l_w = w_in;
                l_a = addr_in;
                l_d = data_in;
                l_m = mask_in;
            end
        end
    end

    task automatic step(input logic v, input logic w, input logic [9:0] a,
                        input logic [BITS-1:0] d, input logic [BITS-1:0] m, input logic y);
        @(posedge clk);
        #1;
        v_in = v;
        w_in = w;
        addr_in = a;
        data_in = d;
        mask_in = m;
        yumi_in = y & v_out;
    endtask

    task automatic idle(input logic y);
        step(1'b0, 1'b0, 10'd0, '0, '0, y);
    endtask

    task automatic do_reset();
        int n;
        @(posedge clk);
        #1;
        rst_n_in = 1'b0;
        v_in = 1'b0;
        w_in = 1'b0;
        yumi_in = 1'b0;
        @(negedge clk);
        chk("v_out_drops_at_reset", v_out, 0);
        repeat (2) @(posedge clk);
        #1 rst_n_in = 1'b1;
        n = 0;
        while (n < 1100) begin
            @(negedge clk);
            if (ready_out) break;
            n++;
        end
        chk("cycles_until_ready", 64'(n), 64'(INIT_CYC));
    endtask

    initial begin
        int n, nr;
        logic [63:0] rnd;
        logic [9:0] a;
        do_reset();

        // Full-mask write then read back.
        step(1, 1, 10'd5, 46'h1234, ONES, 1);
        step(1, 0, 10'd5, '0, '0, 1);
        idle(1);
        idle(1);
        @(negedge clk);
        chk("t1_v_out", v_out, 1);
        chk("t1_data", data_out, 46'h1234);
        idle(1);

        // Partial mask write.
        step(1, 1, 10'd5, 46'h3FFF, ONES, 1);
        step(1, 1, 10'd5, '0, 46'hFF, 1);
        step(1, 0, 10'd5, '0, '0, 1);
        idle(1);
        idle(1);
        @(negedge clk);
        chk("t2_data", data_out, 46'h3F00);
        idle(1);

        // Back-to-back reads with continuous consumption.
        for (int i = 0; i < 8; i++) step(1, 1, 10'(16 + i), 46'(64'h100 + i), ONES, 1);
        n = 0;
        nr = 0;
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 10'(16 + i), '0, '0, 1);
            @(negedge clk);
            if (ready_out) n++;
            if (v_out) nr++;
        end
        for (int i = 0; i < 3; i++) begin
            idle(1);
            @(negedge clk);
            if (v_out) nr++;
        end
        chk("t3_accepts", 64'(n), 8);
        chk("t3_responses", 64'(nr), 8);

        // Back-pressure: only two reads fit.
        n = 0;
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 10'(16 + i), '0, '0, 0);
            @(negedge clk);
            if (ready_out) n++;
        end
        chk("t4_accepts", 64'(n), 2);
        idle(0);
        nr = 0;
        for (int i = 0; i < 4; i++) begin
            idle(1);
            @(negedge clk);
            if (v_out && yumi_in) nr++;
        end
        chk("t4_drained", 64'(nr), 2);
        step(1, 0, 10'd17, '0, '0, 1);
        @(negedge clk);
        chk("t4_resume", ready_out, 1);
        idle(1);
        idle(1);
        idle(1);

        // Reset with one queued response and one read in flight.
        step(1, 0, 10'd16, '0, '0, 0);
        step(1, 0, 10'd17, '0, '0, 0);
        do_reset();
        nr = 0;
        for (int i = 0; i < 6; i++) begin
            idle(1);
            @(negedge clk);
            if (v_out) nr++;
        end
        chk("t5_no_stale", 64'(nr), 0);

`ifdef FAKERAM_CTRL_INIT_EN
        step(1, 0, 10'd1023, '0, '0, 1);
        idle(1);
        idle(1);
        @(negedge clk);
        chk("t6_v_out", v_out, 1);
        chk("t6_data", data_out, 0);
        idle(1);
`endif

        // Randomized traffic over a small address window.
        for (int i = 0; i < 400; i++) begin
            rnd = {$urandom(), $urandom()};
            a = 10'($urandom_range(0, 31));
            step($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, a, rnd[BITS-1:0],
                 ($urandom_range(0, 3) == 0) ? 46'({$urandom(), $urandom()}) : ONES,
                 $urandom_range(0, 9) < 7);
        end
        for (int i = 0; i < 8; i++) idle(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
